// File: rtl/uart_tx.sv
// Byte-wide 8N1 UART transmitter with a one-deep holding register.
// Frames leave LSB first at BAUD_CNT clocks per bit; back-to-back frames have no idle gap.
module uart_tx #(
    parameter int BAUD_CNT = 56
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       pi_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       hold, hold_nxt;
    logic             full, full_nxt;
    logic             pend, pend_nxt;
    logic             baud_end;
    logic             accept;
    logic             direct_load;

    assign baud_end = (cnt == CNT_LAST);
    assign accept   = pi_flag && pi_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            hold     <= '0;
            full     <= 1'b0;
            pend     <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            pi_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            hold     <= hold_nxt;
            full     <= full_nxt;
            pend     <= pend_nxt;
            // Outputs are registered from next-state values so they line up with
            // the state; the pend cycle in IDLE supplies the one-cycle launch latency.
            tx       <= (state_nxt == START) ? 1'b0 :
                        (state_nxt == DATA)  ? shift_nxt[0] : 1'b1;
            tx_busy  <= (state_nxt != IDLE);
            tx_done  <= (state_nxt == STOP) && (cnt_nxt == CNT_LAST);
            pi_ready <= !full_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_nxt     = bit_idx;
        shift_nxt   = shift;
        hold_nxt    = hold;
        full_nxt    = full;
        pend_nxt    = pend;
        direct_load = 1'b0;

        case (state)
            IDLE: begin
                if (pend) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    pend_nxt  = 1'b0;
                end else if (accept) begin
                    shift_nxt   = pi_data;
                    pend_nxt    = 1'b1;
                    direct_load = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_nxt = '0;
                    if (full) begin
                        shift_nxt = hold;
                        full_nxt  = 1'b0;
                        state_nxt = START;
                    end else if (pi_flag) begin
                        shift_nxt   = pi_data;
                        direct_load = 1'b1;
                        state_nxt   = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (accept && !direct_load) begin
            hold_nxt = pi_data;
            full_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected frames, a line monitor
// decodes tx and checks framing, timing and contiguity against the queue.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic [7:0] d0, d1;
    logic       f0, f1;
    logic       rdy0, rdy1, tx0, tx1, bsy0, bsy1, dn0, dn1;

    uart_tx #(.BAUD_CNT(56)) u0 (
        .clk(clk), .rst(rst0), .pi_data(d0), .pi_flag(f0),
        .pi_ready(rdy0), .tx(tx0), .tx_busy(bsy0), .tx_done(dn0)
    );

    uart_tx #(.BAUD_CNT(2)) u1 (
        .clk(clk), .rst(rst1), .pi_data(d1), .pi_flag(f1),
        .pi_ready(rdy1), .tx(tx1), .tx_busy(bsy1), .tx_done(dn1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         unit;
        logic [7:0] data;
        bit         contig;
    } exp_t;
    exp_t sb[$];

    int         cyc[2];
    int         fcyc[2];
    int         start_cyc[2];
    int         last_end[2];
    int         run[2];
    int         last_run[2];
    bit         in_f[2];
    bit         have[2];
    logic [9:0] ef[2];
    logic [9:0] got[2];

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
        bad++;
        if (bad <= 25)
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) report(name, act, req);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) report(name, 32'(act), 32'(req));
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        report(name, act, 32'd0);
    endtask

    // Line monitor: one call per unit per falling clock edge.
    task automatic mon_step(input int u, input int b, input logic rn,
                            input logic t, input logic bs, input logic dn);
        exp_t e;
        cyc[u]++;
        if (!rn) begin
            in_f[u] = 1'b0;
            run[u]  = 0;
        end else begin
            if (bs) run[u]++;
            else if (run[u] != 0) begin
                last_run[u] = run[u];
                run[u]      = 0;
            end
            if (!in_f[u] && t === 1'b0) begin
                in_f[u]      = 1'b1;
                fcyc[u]      = 0;
                start_cyc[u] = cyc[u];
                have[u]      = (sb.size() > 0);
                if (have[u]) begin
                    ef[u] = {1'b1, sb[0].data, 1'b0};
                    if (sb[0].contig) chk("no_gap", 32'(start_cyc[u]), 32'(last_end[u] + 1));
                end
            end
            if (!in_f[u]) begin
                chk1("idle_busy", bs, 1'b0);
                chk1("idle_done", dn, 1'b0);
            end else begin
                chk1("frame_busy", bs, 1'b1);
                chk1("done_pos", dn, fcyc[u] == 10 * b - 1);
                if (have[u]) chk1("tx_bit", t, ef[u][fcyc[u] / b]);
                if (fcyc[u] % b == b / 2) got[u][fcyc[u] / b] = t;
                if (fcyc[u] == 10 * b - 1) begin
                    last_end[u] = cyc[u];
                    in_f[u]     = 1'b0;
                    if (sb.size() == 0) begin
                        fail_now("unexpected_frame", 32'(got[u][8:1]));
                    end else begin
                        e = sb.pop_front();
                        chk("unit", 32'(u), 32'(e.unit));
                        chk("data", 32'(got[u][8:1]), 32'(e.data));
                        chk("start_stop", 32'({got[u][9], got[u][0]}), 32'd2);
                    end
                end
                fcyc[u]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, 56, rst0, tx0, bsy0, dn0);
        mon_step(1, 2, rst1, tx1, bsy1, dn1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int u, input logic [7:0] d);
        if (u == 0) begin
            d0 = d; f0 = 1'b1; tick(); f0 = 1'b0;
        end else begin
            d1 = d; f1 = 1'b1; tick(); f1 = 1'b0;
        end
    endtask

    task automatic expect_byte(input int u, input logic [7:0] d, input bit contig);
        exp_t e;
        e.unit = u; e.data = d; e.contig = contig;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int u, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0 && ((u == 0) ? bsy0 : bsy1) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("idle_timeout", 32'(sb.size()));
        repeat (2) tick();
    endtask

    task automatic wait_ready(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rdy0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("ready_timeout", 32'(rdy0));
    endtask

    task automatic wait_done(input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (dn0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_now("done_timeout", 32'(dn0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb [4];
        lb = '{8'h12, 8'h34, 8'hAB, 8'hFF};
        rst0 = 1'b1; rst1 = 1'b1;
        f0 = 1'b0; f1 = 1'b0; d0 = '0; d1 = '0;
        #1 rst0 = 1'b0; rst1 = 1'b0;
        #2;
        chk1("rst_tx", tx0, 1'b1);
        chk1("rst_busy", bsy0, 1'b0);
        chk1("rst_done", dn0, 1'b0);
        chk1("rst_ready", rdy0, 1'b1);
        chk1("rst_tx_b2", tx1, 1'b1);
        chk1("rst_ready_b2", rdy1, 1'b1);
        repeat (3) tick();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) tick();

        // Single byte 0x55 and launch latency
        expect_byte(0, 8'h55, 1'b0);
        strobe(0, 8'h55);
        chk1("launch_tx_still_high", tx0, 1'b1);
        chk1("launch_busy_still_low", bsy0, 1'b0);
        tick();
        chk1("launch_tx_low", tx0, 1'b0);
        chk1("launch_busy_high", bsy0, 1'b1);
        wait_idle(0, 3000);
        chk("single_busy_len", 32'(last_run[0]), 32'd560);

        // Loopback sequence, each byte sent once pi_ready is high
        for (int i = 0; i < 4; i++) begin
            wait_ready(2000);
            expect_byte(0, lb[i], 1'b0);
            strobe(0, lb[i]);
        end
        wait_idle(0, 4000);

        // Back-to-back: 0xA0, 0x0F two cycles later, 0x33 dropped
        expect_byte(0, 8'hA0, 1'b0);
        expect_byte(0, 8'h0F, 1'b1);
        d0 = 8'hA0; f0 = 1'b1; tick();
        f0 = 1'b0; tick();
        d0 = 8'h0F; f0 = 1'b1; tick();
        chk1("b2b_ready_low", rdy0, 1'b0);
        d0 = 8'h33; tick();
        f0 = 1'b0;
        wait_done(1000);
        chk1("ready_low_at_done", rdy0, 1'b0);
        tick();
        chk1("ready_rise_after_done", rdy0, 1'b1);
        chk1("b2b_next_start", tx0, 1'b0);
        wait_idle(0, 1000);
        chk("b2b_busy_len", 32'(last_run[0]), 32'd1120);

        // Strobe in the final STOP cycle with the holding register empty
        expect_byte(0, 8'h3C, 1'b0);
        strobe(0, 8'h3C);
        wait_done(1000);
        expect_byte(0, 8'hC3, 1'b1);
        chk1("stop_strobe_ready", rdy0, 1'b1);
        d0 = 8'hC3; f0 = 1'b1; tick();
        f0 = 1'b0;
        chk1("stop_strobe_ready_after", rdy0, 1'b1);
        chk1("stop_strobe_start", tx0, 1'b0);
        wait_idle(0, 1000);
        chk("stop_strobe_busy_len", 32'(last_run[0]), 32'd1120);

        // Reset during data bit 3 of 0xF0, holding register full with 0x77
        strobe(0, 8'hF0);
        tick();
        strobe(0, 8'h77);
        repeat (249) tick();
        chk1("pre_rst_tx_bit3", tx0, 1'b0);
        chk1("pre_rst_ready", rdy0, 1'b0);
        #2 rst0 = 1'b0;
        #1;
        chk1("midrst_tx", tx0, 1'b1);
        chk1("midrst_busy", bsy0, 1'b0);
        chk1("midrst_done", dn0, 1'b0);
        chk1("midrst_ready", rdy0, 1'b1);
        repeat (2) tick();
        rst0 = 1'b1;
        repeat (2) tick();
        expect_byte(0, 8'h81, 1'b0);
        strobe(0, 8'h81);
        wait_idle(0, 1000);
        chk("after_rst_busy_len", 32'(last_run[0]), 32'd560);

        // BAUD_CNT = 2 instance
        expect_byte(1, 8'h01, 1'b0);
        strobe(1, 8'h01);
        wait_idle(1, 200);
        chk("b2_busy_len", 32'(last_run[1]), 32'd20);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
